// File: rtl/core_ibex_dv_pkg.sv
// Shared types and defaults for the core_ibex DV stimulus blocks.
package core_ibex_dv_pkg;

  typedef enum logic [1:0] {
    DbgGenIdle,
    DbgGenWait,
    DbgGenReq,
    DbgGenDebug
  } dbg_gen_state_e;

  localparam int unsigned DefaultMaxReqCycles = 1024;

endpackage

// File: rtl/core_ibex_debug_req_gen.sv
// Periodic debug-request generator: waits a programmable interval, raises debug_req until the
// core enters debug mode, then waits for dret before re-arming. Flags a sticky timeout on no ack.
module core_ibex_debug_req_gen
  import core_ibex_dv_pkg::*;
#(
  parameter int unsigned IntervalW    = 16,
  parameter int unsigned MaxReqCycles = DefaultMaxReqCycles,
  parameter int unsigned CountW       = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic                 single_shot_i,
  input  logic [IntervalW-1:0] interval_i,
  input  logic                 fetch_en_i,
  input  logic                 debug_mode_i,
  input  logic                 dret_i,
  output logic                 debug_req_o,
  output logic                 busy_o,
  output logic [CountW-1:0]    req_count_o,
  output logic                 timeout_o
);

  localparam int unsigned TmrW = (MaxReqCycles > 1) ? $clog2(MaxReqCycles) : 1;
  localparam logic [TmrW-1:0] TmrLast = TmrW'(MaxReqCycles - 1);

  dbg_gen_state_e state_q, state_d;
  logic [IntervalW-1:0] cnt_q, cnt_d;
  logic [TmrW-1:0]      tmr_q, tmr_d;
  logic [CountW-1:0]    count_q, count_d;
  logic                 req_q, req_d;
  logic                 timeout_q, timeout_d;

  logic armed;
  assign armed = enable_i && fetch_en_i;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmr_d     = tmr_q;
    count_d   = count_q;
    req_d     = req_q;
    timeout_d = timeout_q;

    unique case (state_q)
      DbgGenIdle: begin
        if (armed && !timeout_q) begin
          cnt_d   = interval_i;
          state_d = DbgGenWait;
        end
      end
      DbgGenWait: begin
        if (!armed) begin
          state_d = DbgGenIdle;
        end else if (cnt_q == '0) begin
          req_d   = 1'b1;
          tmr_d   = '0;
          state_d = DbgGenReq;
        end else begin
          cnt_d = cnt_q - IntervalW'(1);
        end
      end
      DbgGenReq: begin
        // Gating inputs are deliberately ignored here: the request holds until ack or timeout.
        if (debug_mode_i) begin
          req_d   = 1'b0;
          state_d = DbgGenDebug;
          if (count_q != '1) begin
            count_d = count_q + CountW'(1);
          end
        end else if (tmr_q == TmrLast) begin
          req_d     = 1'b0;
          timeout_d = 1'b1;
          state_d   = DbgGenIdle;
        end else begin
          tmr_d = tmr_q + TmrW'(1);
        end
      end
      DbgGenDebug: begin
        // Leaving debug mode without a dret pulse is treated as a dret.
        if (dret_i || !debug_mode_i) begin
          if (single_shot_i || !armed) begin
            state_d = DbgGenIdle;
          end else begin
            cnt_d   = interval_i;
            state_d = DbgGenWait;
          end
        end
      end
      default: state_d = DbgGenIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= DbgGenIdle;
      cnt_q     <= '0;
      tmr_q     <= '0;
      count_q   <= '0;
      req_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmr_q     <= tmr_d;
      count_q   <= count_d;
      req_q     <= req_d;
      timeout_q <= timeout_d;
    end
  end

  assign debug_req_o = req_q;
  assign busy_o      = (state_q != DbgGenIdle);
  assign req_count_o = count_q;
  assign timeout_o   = timeout_q;

endmodule
